regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port (rd_num/rd_data/rd_we) between NREQ writeback sources
//  (e.g. ALU, load unit, mult/div unit).
//  - Round-robin arbitration, one grant per cycle, registered write stage.
//  - Holds a per-register busy scoreboard so issue logic can stall on RAW/WAW hazards.
//  - Raises drained on halt so the register dump is taken only after every in-flight write has landed.
// PARAMETERS
//  XLEN  32  data width; matches the register file
//  NREQ  3   number of writeback requesters (2..8)
//  NREG  32  number of architectural registers; fixes the busy_vec width
// PORTS
//  clk        in   1          clock; all state updates on posedge
//  rst        in   1          asynchronous, active-high reset
//  req_valid  in   NREQ       requester i has a pending write
//  req_ready  out  NREQ       one-hot grant; transfer when req_valid[i] & req_ready[i]
//  req_num    in   NREQ*5     destination register; slice i = [5*i+4:5*i]
//  req_data   in   NREQ*XLEN  write data; slice i = [XLEN*i+XLEN-1:XLEN*i]
//  rd_num     out  5          to regfile rd_num (registered)
//  rd_data    out  XLEN       to regfile rd_data (registered)
//  rd_we      out  1          to regfile rd_we (registered)
//  rsv_valid  in   1          issue stage reserves rsv_num as a pending destination
//  rsv_num    in   5          register being reserved
//  rsv_ready  out  1          reservation accepted this cycle
//  chk_rs_num in   5          source operand 1 to hazard-check
//  chk_rt_num in   5          source operand 2 to hazard-check
//  chk_busy   out  1          either source register is busy (combinational)
//  busy_vec   out  NREG       scoreboard state
//  halted     in   1          processor halted
//  drained    out  1          no pending or in-flight writes remain
// BEHAVIOUR
//  Reset (rst=1, async)
//   - rd_we=0, rd_num=0, rd_data=0, busy_vec=0, rr_ptr=0, req_ready=0.
//   - A write held in the output stage is discarded.
//  Arbitration
//   - Combinational scan of req_valid starting at index rr_ptr, wrapping modulo NREQ.
//   - The first valid index found is granted; req_ready is one-hot or all-zero.
//   - On a grant to index g: rr_ptr <= (g+1)%NREQ. With no grant, rr_ptr holds its value.
//   - A requester holds valid/num/data stable until granted. Dropping valid before the grant is legal.
//  Latency
//   - Grant in cycle t loads the output stage: rd_we=1, rd_num and rd_data valid in cycle t+1.
//   - The regfile captures the write at the end of cycle t+1.
//   - No grant in cycle t gives rd_we=0 in cycle t+1. rd_num/rd_data hold their previous values.
//   - Full throughput: one write per cycle, no bubbles.
//  Scoreboard
//   - rsv_ready = ~busy_vec[rsv_num] & ~halted.
//   - On rsv_valid & rsv_ready: busy_vec[rsv_num] <= 1.
//   - A clock edge with rd_we=1 clears busy_vec[rd_num].
//   - Writes without a prior reservation are legal; they only clear busy_vec.
//   - Set and clear of the same register in one cycle cannot occur (rsv_ready=0 while busy).
//     Set and clear of different registers both apply.
//   - chk_busy = busy_vec[chk_rs_num] | busy_vec[chk_rt_num]. No bypass: a register clearing this
//     cycle still reports busy.
//  Halt
//   - halted=1 forces rsv_ready=0. Arbitration continues.
//   - drained = halted & ~|req_valid & ~rd_we & ~|busy_vec (combinational).
// CONFIGURATION
//  RFARB_R0_DROP_EN defined
//   - A grant whose req_num==0 is acknowledged normally, but rd_we stays 0 in cycle t+1.
//   - Reserving r0 is accepted, but busy_vec[0] is never set.
//   - chk_busy ignores r0.
//  RFARB_R0_DROP_EN undefined
//   - r0 is treated like every other register.
// TESTING
//  - Reset mid-write: rst=1 while rd_we=1, rd_num=5 -> rd_we=0 in the same cycle, busy_vec=0,
//    rr_ptr=0, regfile r5 unchanged.
//  - Round-robin: req_valid=3'b111 held for 6 cycles -> grants 0,1,2,0,1,2.
//    Then only req 1 valid -> granted every cycle.
//  - Latency: req 2 valid, num=7, data=0xDEADBEEF at cycle t -> cycle t+1 shows rd_we=1, rd_num=7,
//    rd_data=0xDEADBEEF. Regfile r7=0xDEADBEEF at t+2.
//  - Scoreboard: reserve r3 -> busy_vec[3]=1, chk_busy=1 for chk_rs_num=3.
//    A second reserve of r3 gives rsv_ready=0. The write to r3 clears the bit on the rd_we edge.
//  - Halt/drain: halted=1 with r4 reserved and req 0 pending -> rsv_ready=0, drained=0.
//    drained=1 the cycle after r4 is written and req_valid=0.
//  - With RFARB_R0_DROP_EN: write to r0 with data=0x1 -> req_ready=1, rd_we stays 0, busy_vec[0]=0.
//    Without the macro: rd_we=1, rd_num=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among NREQ writeback sources,
// with a per-register busy scoreboard and halt drain detection. Optional: RFARB_R0_DROP_EN.
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREQ = 3,
  parameter int NREG = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*5-1:0]    req_num,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [4:0]           rd_num,
  output logic [XLEN-1:0]      rd_data,
  output logic                 rd_we,
  input  logic                 rsv_valid,
  input  logic [4:0]           rsv_num,
  output logic                 rsv_ready,
  input  logic [4:0]           chk_rs_num,
  input  logic [4:0]           chk_rt_num,
  output logic                 chk_busy,
  output logic [NREG-1:0]      busy_vec,
  input  logic                 halted,
  output logic                 drained
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTRW-1:0] rr_ptr_r;
  logic [PTRW-1:0] scan_idx_s;
  logic [PTRW-1:0] gnt_idx_s;
  logic [PTRW-1:0] ptr_next_s;
  logic            scan_hit_s;
  logic            gnt_any_s;
  logic [NREQ-1:0] gnt_s;
  logic [4:0]      sel_num_s;
  logic [XLEN-1:0] sel_data_s;
  logic            wr_keep_s;
  logic            rsv_keep_s;
  logic            rsv_set_s;
  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] busy_next_s;
  logic            rd_we_r;
  logic [4:0]      rd_num_r;
  logic [XLEN-1:0] rd_data_r;

  // Scan from rr_ptr, wrapping, and grant the first valid requester; nothing is granted in reset.
  always_comb begin
    gnt_s      = '0;
    gnt_idx_s  = '0;
    gnt_any_s  = 1'b0;
    scan_idx_s = '0;
    scan_hit_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx_s            = PTRW'((int'(rr_ptr_r) + k) % NREQ);
      scan_hit_s            = ~gnt_any_s & req_valid[scan_idx_s] & ~rst;
      gnt_s[scan_idx_s]     = gnt_s[scan_idx_s] | scan_hit_s;
      gnt_idx_s             = scan_hit_s ? scan_idx_s : gnt_idx_s;
      gnt_any_s             = gnt_any_s | scan_hit_s;
    end
  end

  // One-hot mux of the granted requester's destination and data.
  always_comb begin
    sel_num_s  = '0;
    sel_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_num_s  = sel_num_s  | ({5{gnt_s[i]}} & req_num[5*i +: 5]);
      sel_data_s = sel_data_s | ({XLEN{gnt_s[i]}} & req_data[XLEN*i +: XLEN]);
    end
  end

  assign ptr_next_s = (gnt_idx_s == PTRW'(NREQ - 1)) ? '0 : gnt_idx_s + PTRW'(1);

`ifdef RFARB_R0_DROP_EN
  // r0 is hardwired: its writes are acknowledged but dropped and it never goes busy.
  assign wr_keep_s  = (sel_num_s != 5'd0);
  assign rsv_keep_s = (rsv_num != 5'd0);
  assign chk_busy   = (busy_r[chk_rs_num] & (chk_rs_num != 5'd0))
                    | (busy_r[chk_rt_num] & (chk_rt_num != 5'd0));
`else
  assign wr_keep_s  = 1'b1;
  assign rsv_keep_s = 1'b1;
  assign chk_busy   = busy_r[chk_rs_num] | busy_r[chk_rt_num];
`endif

  assign rsv_ready = ~busy_r[rsv_num] & ~halted;
  assign rsv_set_s = rsv_valid & rsv_ready & rsv_keep_s;

  // Scoreboard next state: the landing write clears, an accepted reservation sets.
  always_comb begin
    busy_next_s           = busy_r;
    busy_next_s[rd_num_r] = busy_next_s[rd_num_r] & ~rd_we_r;
    busy_next_s[rsv_num]  = busy_next_s[rsv_num] | rsv_set_s;
  end

  // Output stage, round-robin pointer and scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r  <= '0;
      rd_we_r   <= 1'b0;
      rd_num_r  <= 5'd0;
      rd_data_r <= '0;
      busy_r    <= '0;
    end else begin
      busy_r  <= busy_next_s;
      rd_we_r <= gnt_any_s & wr_keep_s;
      if (gnt_any_s) begin
        rr_ptr_r  <= ptr_next_s;
        rd_num_r  <= sel_num_s;
        rd_data_r <= sel_data_s;
      end else begin
        rr_ptr_r  <= rr_ptr_r;
        rd_num_r  <= rd_num_r;
        rd_data_r <= rd_data_r;
      end
    end
  end

  assign req_ready = gnt_s;
  assign rd_we     = rd_we_r;
  assign rd_num    = rd_num_r;
  assign rd_data   = rd_data_r;
  assign busy_vec  = busy_r;
  assign drained   = halted & ~|req_valid & ~rd_we_r & ~|busy_r;

endmodule
